// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the MIPS datapath.
// Memory width codes (shared with the control decoder) and the memory-stage FSM states.
package cpu_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_B    = 2'b01;
    localparam logic [1:0] MEM_H    = 2'b10;
    localparam logic [1:0] MEM_W    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory bus.
// master drives req/we/addr/be/wdata; slave returns rdata/ack.
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_lane.sv
// mem_lane: little-endian lane logic for byte/half/word accesses.
// in: width, lo (addr[1:0]), sdata, word; out: be, wdata, ldata, misalign.
module mem_lane
    import cpu_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  lo,
    input  logic [31:0] sdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{lo, 3'b000} +: 8];
    assign lane_h = word[{lo[1], 4'b0000} +: 16];

    always_comb begin
        be       = 4'b0000;
        wdata    = sdata;
        ldata    = '0;
        misalign = 1'b0;
        case (width)
            MEM_B: begin
                be    = 4'b0001 << lo;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{lane_b[7]}}, lane_b};
            end
            MEM_H: begin
                be       = lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{lane_h[15]}}, lane_h};
                misalign = lo[0];
            end
            MEM_W: begin
                be       = 4'b1111;
                ldata    = word;
                misalign = (lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage, stalls the core until each access retires.
// in: clk, rst, MemRead, MemWrite, addr, wdata; out: stall, done, err, rdata; bus: memory master.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         MemRead,
    input  logic [1:0]         MemWrite,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               stall,
    output logic               done,
    output logic               err,
    output logic [31:0]        rdata,
    mem_access_unit_if.master  bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mem_state_t state, state_nx;

    logic [1:0]    width_q;
    logic [1:0]    lo_q;
    logic          we_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [3:0]    be_q;

    logic        req;
    logic        is_wr;
    logic        conflict;
    logic [1:0]  live_width;
    logic [1:0]  ln_width;
    logic [1:0]  ln_lo;
    logic [3:0]  ln_be;
    logic [31:0] ln_wdata;
    logic [31:0] ln_ldata;
    logic        ln_mis;
    logic        ack_hit;
    logic        to_hit;

    // A write takes precedence when the decoder asserts both.
    assign is_wr      = (MemWrite != MEM_NONE);
    assign req        = is_wr || (MemRead != MEM_NONE);
    assign conflict   = is_wr && (MemRead != MEM_NONE);
    assign live_width = is_wr ? MemWrite : MemRead;

    // Lane logic sees live inputs when accepting, latched ones during the access.
    assign ln_width = (state == IDLE) ? live_width : width_q;
    assign ln_lo    = (state == IDLE) ? addr[1:0]  : lo_q;

    mem_lane u_lane (
        .width    (ln_width),
        .lo       (ln_lo),
        .sdata    (wdata),
        .word     (bus.mem_rdata),
        .be       (ln_be),
        .wdata    (ln_wdata),
        .ldata    (ln_ldata),
        .misalign (ln_mis)
    );

    assign ack_hit = (state == ACCESS) && bus.mem_ack;
    assign to_hit  = (state == ACCESS) && !bus.mem_ack && (TIMEOUT != 0)
                     && (int'(cnt) == TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = ln_mis ? DONE : ACCESS;
            ACCESS:  if (ack_hit || to_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q <= MEM_NONE;
            lo_q    <= 2'b00;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        width_q <= live_width;
                        lo_q    <= addr[1:0];
                        we_q    <= is_wr;
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= ln_be;
                        wdata_q <= ln_wdata;
                        err_q   <= ln_mis || conflict;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        if (!we_q) rdata_q <= ln_ldata;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (int'(cnt) < TIMEOUT) begin
                        // Saturates at TIMEOUT so the counter never wraps.
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign stall = ((state == IDLE) && req) || (state == ACCESS);
    assign done  = (state == DONE);
    assign err   = (state == DONE) && err_q;
    assign rdata = rdata_q;

    assign bus.mem_req   = (state == ACCESS);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized checks of mem_access_unit
// against an arithmetic reference model of lanes, latency and retire results.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .bus      (bus)
    );

    int n_cmp;
    int n_bad;
    logic [31:0] exp_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts in an IDLE cycle, #1 after a rising edge; ends in the next IDLE cycle.
    task automatic run_access(input logic [1:0] mr, input logic [1:0] mw,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] word, input int waits);
        logic [1:0]  w;
        logic [1:0]  lo;
        logic        wr;
        logic        mis;
        logic        timed_out;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        int          v;
        int          exp_done;
        int          exp_req;
        int          req_cycles;
        int          done_cyc;
        logic        got_done;

        wr  = (mw != 2'b00);
        w   = wr ? mw : mr;
        lo  = a[1:0];
        mis = (w == 2'd2 && lo[0]) || (w == 2'd3 && lo != 2'd0);
        timed_out = !mis && (waits >= TO);
        exp_err = mis || (mr != 2'b00 && mw != 2'b00) || timed_out;

        exp_be = 4'b1111;
        exp_wd = wd;
        exp_ld = word;
        if (w == 2'd1) begin
            exp_be = 4'(1 << lo);
            exp_wd = 32'(wd[7:0]) * 32'h0101_0101;
            v = int'((word >> (8 * lo)) & 32'hFF);
            if (v >= 128) v -= 256;
            exp_ld = 32'(v);
        end else if (w == 2'd2) begin
            exp_be = lo[1] ? 4'b1100 : 4'b0011;
            exp_wd = 32'(wd[15:0]) * 32'h0001_0001;
            v = int'((word >> (16 * lo[1])) & 32'hFFFF);
            if (v >= 32768) v -= 65536;
            exp_ld = 32'(v);
        end

        exp_done = mis ? 1 : (timed_out ? 1 + TO : 2 + waits);
        exp_req  = mis ? 0 : (timed_out ? TO : waits + 1);

        MemRead       = mr;
        MemWrite      = mw;
        addr          = a;
        wdata         = wd;
        bus.mem_rdata = word;
        bus.mem_ack   = 1'($urandom_range(1));
        #1;
        chk("stall_c0", {31'd0, stall}, 32'd1);

        req_cycles = 0;
        done_cyc   = -1;
        got_done   = 1'b0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
                chk("err", {31'd0, err}, {31'd0, exp_err});
                chk("stall_done", {31'd0, stall}, 32'd0);
                if (timed_out) exp_rdata = 32'd0;
                else if (!mis && !wr) exp_rdata = exp_ld;
                chk("rdata_done", rdata, exp_rdata);
            end else if (bus.mem_req) begin
                req_cycles++;
                chk("stall_acc", {31'd0, stall}, 32'd1);
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
                chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
                chk("mem_be", {28'd0, bus.mem_be}, {28'd0, exp_be});
                if (wr) chk("mem_wdata", bus.mem_wdata, exp_wd);
                bus.mem_ack = (req_cycles == waits + 1);
            end
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("req_cycles", 32'(req_cycles), 32'(exp_req));

        MemRead  = 2'b00;
        MemWrite = 2'b00;
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("rdata_held", rdata, exp_rdata);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        exp_rdata     = 32'd0;
        rst           = 1'b1;
        MemRead       = 2'b00;
        MemWrite      = 2'b00;
        addr          = 32'd0;
        wdata         = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_access(2'd3, 2'd0, 32'h0000_0010, 32'h0, 32'h8000_1234, 0);
        run_access(2'd1, 2'd0, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1);
        run_access(2'd2, 2'd0, 32'h0000_0012, 32'h0, 32'h80FF_0000, 0);
        run_access(2'd0, 2'd2, 32'h0000_0022, 32'hDEAD_BEEF, 32'h1111_2222, 3);
        run_access(2'd3, 2'd0, 32'h0000_0006, 32'h0, 32'h5555_AAAA, 0);
        run_access(2'd0, 2'd2, 32'h0000_0001, 32'h1234_5678, 32'h0, 0);
        run_access(2'd3, 2'd0, 32'h0000_0040, 32'h0, 32'h7777_7777, 99);
        run_access(2'd3, 2'd3, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, 1);

        // Reset in the middle of an access abandons it without a retire.
        MemRead     = 2'd3;
        addr        = 32'h0000_0100;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_req_up", {31'd0, bus.mem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("mid_no_done", {31'd0, done}, 32'd0);
        MemRead = 2'd0;
        #1;
        chk("mid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rdata = 32'd0;
        chk("mid_done_after", {31'd0, done}, 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            logic [1:0] mr;
            logic [1:0] mw;
            mr = 2'($urandom_range(3));
            mw = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'd0;
            if (mr == 2'd0 && mw == 2'd0) mr = 2'd3;
            run_access(mr, mw, $urandom, $urandom, $urandom,
                       int'($urandom_range(6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
